// File: rtl/outlier_collector.sv
// Merges outlier positions from CORE_NUMBER validator cores into one FIFO write port.
// Optional feature macro OUTLIER_COUNT_EN adds a wrapping outlier_count of FIFO writes.
module outlier_collector #(
    parameter int N           = 16,
    parameter int CORE_NUMBER = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CORE_NUMBER-1:0]        req_valid,
    input  logic [2*N*CORE_NUMBER-1:0]    req_pos,
    output logic [CORE_NUMBER-1:0]        req_ready,
    input  logic                          flush,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [2*N-1:0]                fifo_din,
    output logic                          drained
`ifdef OUTLIER_COUNT_EN
    ,
    output logic [2*N-1:0]                outlier_count
`endif
);

    localparam int W  = 2 * N;
    localparam int PW = $clog2(CORE_NUMBER);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CORE_NUMBER-1:0]  pending_r;
    logic [CORE_NUMBER-1:0]  pending_s;
    logic [CORE_NUMBER-1:0]  accept_s;
    logic [CORE_NUMBER-1:0]  grant_mask_s;
    logic [CORE_NUMBER-1:0]  ready_s;
    logic [W-1:0]            pos_r [CORE_NUMBER];
    logic [PW-1:0]           rr_ptr_r;
    logic [PW-1:0]           grant_idx_s;
    logic [PW-1:0]           rr_next_s;
    logic [PW-1:0]           scan_idx_s;
    logic                    grant_s;

    // Round-robin search: scanning downward lets the index closest to rr_ptr win
    always_comb begin
        grant_idx_s = {PW{1'b0}};
        scan_idx_s  = {PW{1'b0}};
        for (int k = CORE_NUMBER - 1; k >= 0; k--) begin
            scan_idx_s  = PW'((int'(rr_ptr_r) + k) % CORE_NUMBER);
            grant_idx_s = pending_r[scan_idx_s] ? scan_idx_s : grant_idx_s;
        end
        grant_s = (|pending_r) & ~fifo_full & (state_r != DONE);
        if (grant_idx_s == PW'(CORE_NUMBER - 1)) begin
            rr_next_s = {PW{1'b0}};
        end else begin
            rr_next_s = grant_idx_s + PW'(1);
        end
    end

    // Flush/drain sequencing
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (flush) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if ((pending_r == {CORE_NUMBER{1'b0}}) && !fifo_wr_en) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = DONE;
            default: state_s = RUN;
        endcase
    end

    // Slot occupancy: a granted slot cannot be accepted on the same edge since its ready is low
    always_comb begin
        accept_s     = req_valid & req_ready;
        grant_mask_s = {{(CORE_NUMBER-1){1'b0}}, grant_s} << grant_idx_s;
        pending_s    = (pending_r | accept_s) & ~grant_mask_s;
        ready_s      = ~pending_s & {CORE_NUMBER{state_s == RUN}};
    end

    // Registered slots, arbiter pointer, FIFO write port and status
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= RUN;
            pending_r  <= {CORE_NUMBER{1'b0}};
            req_ready  <= {CORE_NUMBER{1'b1}};
            rr_ptr_r   <= {PW{1'b0}};
            fifo_wr_en <= 1'b0;
            fifo_din   <= {W{1'b0}};
            drained    <= 1'b0;
            for (int i = 0; i < CORE_NUMBER; i++) begin
                pos_r[i] <= {W{1'b0}};
            end
        end else begin
            state_r    <= state_s;
            pending_r  <= pending_s;
            req_ready  <= ready_s;
            fifo_wr_en <= grant_s;
            drained    <= (state_s == DONE);
            if (grant_s) begin
                fifo_din <= pos_r[grant_idx_s];
                rr_ptr_r <= rr_next_s;
            end
            for (int i = 0; i < CORE_NUMBER; i++) begin
                if (accept_s[i]) begin
                    pos_r[i] <= req_pos[i*W +: W];
                end
            end
        end
    end

`ifdef OUTLIER_COUNT_EN
    // Count of cycles with the FIFO write strobe high
    always_ff @(posedge clock) begin
        if (reset) begin
            outlier_count <= {W{1'b0}};
        end else if (fifo_wr_en) begin
            outlier_count <= outlier_count + W'(1);
        end
    end
`endif

endmodule
